// File: rtl/drum_dot_acc.sv
// Streaming dot-product sequencer around an external DRUM multiplier.
// Ports: in_* operand stream, drum_a/b/r multiplier link, out_* held result.
module drum_dot_acc #(
  parameter int OP_W    = 8,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic [OP_W-1:0]   drum_a,
  output logic [OP_W-1:0]   drum_b,
  input  logic [2*OP_W-1:0] drum_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [4:0]        out_len,
  output logic              out_ovf
);

  typedef enum logic [1:0] {
    S_ACC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [OP_W-1:0]  r_a;
  logic [OP_W-1:0]  r_b;
  logic             r_p1_valid;
  logic             r_p1_last;
  logic [4:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic [4:0]       r_out_len;

  logic             w_accept;
  logic             w_force;
  logic             w_end;
  logic             w_retire;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;

  assign in_ready  = (r_state == S_ACC);
  assign drum_a    = r_a;
  assign drum_b    = r_b;
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_len   = r_out_len;
  assign out_ovf   = r_ovf;

  assign w_accept = in_valid & in_ready;
  assign w_force  = (r_cnt == 5'(MAX_LEN - 1));
  assign w_end    = w_accept & (in_last | w_force);
  assign w_retire = r_out_valid & out_ready;

  // drum_r taken as two's complement; size cast sign-extends
  assign w_prod = ACC_W'($signed(drum_r));
  assign w_sum  = r_acc + w_prod;
  assign w_ovf  = (r_acc[ACC_W-1] == w_prod[ACC_W-1]) &
                  (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_ACC:   if (w_end) w_state_nx = S_DRAIN;
      S_DRAIN: if (r_p1_valid & r_p1_last) w_state_nx = S_OUT;
      S_OUT:   if (w_retire) w_state_nx = S_ACC;
      default: w_state_nx = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_p1_valid  <= 1'b0;
      r_p1_last   <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_len   <= '0;
    end else begin
      r_p1_valid <= w_accept;
      if (w_accept) begin
        r_a       <= in_a;
        r_b       <= in_b;
        r_p1_last <= in_last | w_force;
        r_cnt     <= r_cnt + 5'd1;
      end
      if (r_p1_valid) begin
        r_acc <= w_sum;
        if (w_ovf) r_ovf <= 1'b1;
        if (r_p1_last) begin
          r_out_acc   <= w_sum;
          r_out_len   <= r_cnt;
          r_out_valid <= 1'b1;
        end
      end
      // retire never coincides with r_p1_valid (only in S_OUT)
      if (w_retire) begin
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_drum_dot_acc.sv
// Bench for drum_dot_acc: table of vectors plus hand-written sequences.
// A simple one's-complement-sign multiplier model stands in for drum.
module tb_drum_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_ready;

  logic        in_ready, in_ready17;
  logic [7:0]  drum_a, drum_b, drum_a17, drum_b17;
  logic [15:0] drum_r, drum_r17;
  logic        out_valid, out_valid17;
  logic [23:0] out_acc;
  logic [16:0] out_acc17;
  logic [4:0]  out_len, out_len17;
  logic        out_ovf, out_ovf17;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] drum_m(logic [7:0] a, logic [7:0] b);
    logic [7:0]  ma;
    logic [7:0]  mb;
    logic [15:0] p;
    ma = a[7] ? ~a : a;
    mb = b[7] ? ~b : b;
    p  = 16'(ma) * 16'(mb);
    return (a[7] ^ b[7]) ? ~p : p;
  endfunction

  assign drum_r   = drum_m(drum_a, drum_b);
  assign drum_r17 = drum_m(drum_a17, drum_b17);

  drum_dot_acc u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .drum_a(drum_a), .drum_b(drum_b), .drum_r(drum_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_len(out_len), .out_ovf(out_ovf)
  );

  drum_dot_acc #(.ACC_W(17)) u_dut17 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready17),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .drum_a(drum_a17), .drum_b(drum_b17), .drum_r(drum_r17),
    .out_valid(out_valid17), .out_ready(out_ready),
    .out_acc(out_acc17), .out_len(out_len17), .out_ovf(out_ovf17)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b, logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    chk("send_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("retire_valid", out_valid, 0);
    chk("retire_rdy", in_ready, 1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [23:0] acc;
    logic [4:0]  len;
    logic        ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'd3,   8'd5,   1'b0, 24'h0,      5'd0, 1'b0};
    tbl[1] = '{8'd10,  8'd4,   1'b0, 24'h0,      5'd0, 1'b0};
    tbl[2] = '{8'd2,   8'd7,   1'b1, 24'd69,     5'd3, 1'b0};
    tbl[3] = '{8'hFF,  8'd5,   1'b1, 24'hFFFFFF, 5'd1, 1'b0};
    tbl[4] = '{8'hFD,  8'd4,   1'b0, 24'h0,      5'd0, 1'b0};
    tbl[5] = '{8'd6,   8'hFE,  1'b1, 24'hFFFFF0, 5'd2, 1'b0};
    tbl[6] = '{8'h80,  8'h80,  1'b1, 24'h003F01, 5'd1, 1'b0};
    tbl[7] = '{8'h00,  8'h55,  1'b0, 24'h0,      5'd0, 1'b0};
    tbl[8] = '{8'h7F,  8'd2,   1'b1, 24'h0000FE, 5'd2, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_drum_a", drum_a, 0);
    chk("rst_drum_b", drum_b, 0);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last) begin
        chk("lat0", out_valid, 0);
        tick();
        chk("lat1", out_valid, 1);
        chk("vec_acc", out_acc, 32'(tbl[i].acc));
        chk("vec_len", out_len, 32'(tbl[i].len));
        chk("vec_ovf", out_ovf, 32'(tbl[i].ovf));
        retire();
      end
    end

    // hold result with out_ready low; inputs must be ignored
    send(8'd3, 8'd5, 1'b0);
    send(8'd10, 8'd4, 1'b0);
    send(8'd2, 8'd7, 1'b1);
    tick();
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", out_acc, 69);
      chk("hold_len", out_len, 3);
      chk("hold_rdy", in_ready, 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    retire();
    send(8'd2, 8'd3, 1'b1);
    tick();
    chk("fresh_acc", out_acc, 6);
    chk("fresh_len", out_len, 1);
    retire();

    // forced end at 16 pairs, 17th pair held at the input
    for (int k = 0; k < 16; k++) send(8'd1, 8'd1, 1'b0);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
    chk("force_rdy", in_ready, 0);
    tick();
    chk("force_valid", out_valid, 1);
    chk("force_acc", out_acc, 16);
    chk("force_len", out_len, 16);
    chk("force_rdy2", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("p17_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("p17_pending", out_valid, 0);
    tick();
    chk("p17_valid", out_valid, 1);
    chk("p17_acc", out_acc, 81);
    chk("p17_len", out_len, 1);
    retire();

    // overflow in the 17-bit instance: 5 x 16129
    for (int k = 0; k < 4; k++) send(8'd127, 8'd127, 1'b0);
    send(8'd127, 8'd127, 1'b1);
    tick();
    chk("ovf17_valid", out_valid17, 1);
    chk("ovf17_acc", out_acc17, 32'h13B05);
    chk("ovf17_flag", out_ovf17, 1);
    chk("ovf17_len", out_len17, 5);
    chk("ovf24_acc", out_acc, 32'h013B05);
    chk("ovf24_flag", out_ovf, 0);
    retire();
    chk("ovf17_clr", out_ovf17, 0);

    // reset mid-vector
    send(8'd3, 8'd5, 1'b0);
    send(8'd10, 8'd4, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mrst_valid", out_valid, 0);
      tick();
    end
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_drum_a", drum_a, 0);
    send(8'd6, 8'd6, 1'b1);
    tick();
    chk("mrst_out_valid", out_valid, 1);
    chk("mrst_acc", out_acc, 36);
    chk("mrst_len", out_len, 1);
    retire();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
